// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared state encoding, direction constants and default timing
//            for the intersection phase controller.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // 3-bit binary state encoding
    localparam logic [2:0] ST_NS_GREEN     = 3'd0;
    localparam logic [2:0] ST_NS_YELLOW    = 3'd1;
    localparam logic [2:0] ST_RED_AFTER_NS = 3'd2;
    localparam logic [2:0] ST_EW_GREEN     = 3'd3;
    localparam logic [2:0] ST_EW_YELLOW    = 3'd4;
    localparam logic [2:0] ST_RED_AFTER_EW = 3'd5;
    localparam logic [2:0] ST_PED_WALK     = 3'd6;

    typedef enum logic [2:0] {
        NS_GREEN     = ST_NS_GREEN,
        NS_YELLOW    = ST_NS_YELLOW,
        RED_AFTER_NS = ST_RED_AFTER_NS,
        EW_GREEN     = ST_EW_GREEN,
        EW_YELLOW    = ST_EW_YELLOW,
        RED_AFTER_EW = ST_RED_AFTER_EW,
        PED_WALK     = ST_PED_WALK
    } state_e;

    // Green direction owed after a pedestrian walk
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    // Default timing (clock cycles per tick, then durations in ticks)
    localparam int DEF_TICK_DIV  = 20;
    localparam int DEF_GREEN_MIN = 3;
    localparam int DEF_GREEN_MAX = 10;
    localparam int DEF_YELLOW_T  = 2;
    localparam int DEF_ALLRED_T  = 1;
    localparam int DEF_WALK_T    = 4;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Brief    : Free-running divider producing a one-cycle strobe every
//            TICK_DIV clock cycles (strobe in the last count of the period).
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    // Count 0..TICK_DIV-1 and wrap
    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (div_cnt_q == C_LAST) begin
            div_cnt_d = '0;
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = (div_cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl
// Brief    : Actuated two-way intersection controller with pedestrian walk
//            phase. Moore lamp decode from the phase state register.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ns_car,
    input  logic ew_car,
    input  logic ped_req,
    output logic tick,
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic ew_g,
    output logic ew_y,
    output logic ew_r,
    output logic walk,
    output logic ped_pending
);

    localparam int            EW      = $clog2(GREEN_MAX + 1);
    localparam logic [EW:0]   C_GMIN  = (EW+1)'(GREEN_MIN);
    localparam logic [EW:0]   C_GMAX  = (EW+1)'(GREEN_MAX);
    localparam logic [EW:0]   C_YEL   = (EW+1)'(YELLOW_T);
    localparam logic [EW:0]   C_AR    = (EW+1)'(ALLRED_T);
    localparam logic [EW:0]   C_WALK  = (EW+1)'(WALK_T);

    state_e        state_q, state_d;
    logic [EW-1:0] elapsed_q, elapsed_d;
    logic          next_dir_q, next_dir_d;
    logic          ped_pending_q, ped_pending_d;
    logic          enter_walk;
    logic [EW:0]   e_val;
    logic [EW-1:0] elapsed_inc;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // e is the tick count this state will have reached after the current tick;
    // the stored count saturates at all-ones instead of wrapping.
    assign e_val       = {1'b0, elapsed_q} + (EW+1)'(1);
    assign elapsed_inc = (elapsed_q == {EW{1'b1}}) ? elapsed_q : e_val[EW-1:0];

    // Next-state, phase timer and walk-direction logic (advances only on tick)
    always_comb begin
        state_d    = state_q;
        elapsed_d  = elapsed_q;
        next_dir_d = next_dir_q;
        enter_walk = 1'b0;
        if (tick) begin
            elapsed_d = elapsed_inc;
            case (state_q)
                NS_GREEN: begin
                    if ((e_val >= C_GMAX) ||
                        ((e_val >= C_GMIN) && (ew_car || ped_pending_q))) begin
                        state_d = NS_YELLOW;
                    end
                end
                NS_YELLOW: begin
                    if (e_val == C_YEL) state_d = RED_AFTER_NS;
                end
                RED_AFTER_NS: begin
                    if (e_val == C_AR) begin
                        if (ped_pending_q) begin
                            state_d    = PED_WALK;
                            next_dir_d = DIR_EW;
                            enter_walk = 1'b1;
                        end else begin
                            state_d = EW_GREEN;
                        end
                    end
                end
                EW_GREEN: begin
                    if ((e_val >= C_GMAX) ||
                        ((e_val >= C_GMIN) && (ns_car || ped_pending_q))) begin
                        state_d = EW_YELLOW;
                    end
                end
                EW_YELLOW: begin
                    if (e_val == C_YEL) state_d = RED_AFTER_EW;
                end
                RED_AFTER_EW: begin
                    if (e_val == C_AR) begin
                        if (ped_pending_q) begin
                            state_d    = PED_WALK;
                            next_dir_d = DIR_NS;
                            enter_walk = 1'b1;
                        end else begin
                            state_d = NS_GREEN;
                        end
                    end
                end
                PED_WALK: begin
                    if (e_val == C_WALK) begin
                        state_d = (next_dir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
                    end
                end
                default: state_d = RED_AFTER_EW;
            endcase
            if (state_d != state_q) begin
                elapsed_d = '0;
            end
        end
    end

    // Pedestrian latch: any press outside the walk sets it, entering the walk
    // clears it and takes priority over a same-edge press
    always_comb begin
        ped_pending_d = ped_pending_q | (ped_req && (state_q != PED_WALK));
        if (enter_walk) begin
            ped_pending_d = 1'b0;
        end
    end

    // State, timer, direction and pedestrian registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RED_AFTER_EW;
            elapsed_q     <= '0;
            next_dir_q    <= DIR_NS;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            elapsed_q     <= elapsed_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Moore lamp decode: exactly one lamp per head, walk only with both red
    always_comb begin
        ns_g = 1'b0;
        ns_y = 1'b0;
        ns_r = 1'b1;
        ew_g = 1'b0;
        ew_y = 1'b0;
        ew_r = 1'b1;
        walk = 1'b0;
        case (state_q)
            NS_GREEN:  begin ns_g = 1'b1; ns_r = 1'b0; end
            NS_YELLOW: begin ns_y = 1'b1; ns_r = 1'b0; end
            EW_GREEN:  begin ew_g = 1'b1; ew_r = 1'b0; end
            EW_YELLOW: begin ew_y = 1'b1; ew_r = 1'b0; end
            PED_WALK:  walk = 1'b1;
            default:   ;
        endcase
    end

    assign ped_pending = ped_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_ctrl
// Brief    : Directed self-checking bench for traffic_phase_ctrl with default
//            timing, followed by a randomized lamp-safety sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic ns_car, ew_car, ped_req;
    logic tick, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Lamp vector {ns_g,ns_y,ns_r, ew_g,ew_y,ew_r, walk}
    localparam logic [6:0] L_RED  = 7'b001_001_0;
    localparam logic [6:0] L_NSG  = 7'b100_001_0;
    localparam logic [6:0] L_NSY  = 7'b010_001_0;
    localparam logic [6:0] L_EWG  = 7'b001_100_0;
    localparam logic [6:0] L_EWY  = 7'b001_010_0;
    localparam logic [6:0] L_WALK = 7'b001_001_1;

    traffic_phase_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ns_car      (ns_car),
        .ew_car      (ew_car),
        .ped_req     (ped_req),
        .tick        (tick),
        .ns_g        (ns_g),
        .ns_y        (ns_y),
        .ns_r        (ns_r),
        .ew_g        (ew_g),
        .ew_y        (ew_y),
        .ew_r        (ew_r),
        .walk        (walk),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    wire [6:0] lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // Advance to the negedge sampling point of the given cycle since release
    task automatic run_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_lamps(input string tag, input int c, input logic [6:0] exp);
        run_to(c);
        check(tag, {1'b0, lamps}, {1'b0, exp});
    endtask

    initial begin
        int nonred;
        rst_n = 1'b0; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;

        // ---- 1: reset and release ----
        repeat (3) @(negedge clk);
        check("rst_lamps", {1'b0, lamps}, {1'b0, L_RED});
        check("rst_tick",  {7'b0, tick}, 8'd0);
        check("rst_ped",   {7'b0, ped_pending}, 8'd0);
        rst_n = 1'b1;
        cyc   = 0;
        run_to(18); check("tick_c18", {7'b0, tick}, 8'd0);
        run_to(19); check("tick_c19", {7'b0, tick}, 8'd1);
        chk_lamps("red_c19", 19, L_RED);
        chk_lamps("nsg_c20", 20, L_NSG);
        check("tick_c20", {7'b0, tick}, 8'd0);

        // ---- 2: fixed-time cycle, no demand ----
        chk_lamps("nsg_end",  219, L_NSG);
        chk_lamps("nsy_beg",  220, L_NSY);
        chk_lamps("nsy_end",  259, L_NSY);
        chk_lamps("ar_ns",    260, L_RED);
        chk_lamps("ewg_beg",  280, L_EWG);
        chk_lamps("ewg_end",  479, L_EWG);
        chk_lamps("ewy_beg",  480, L_EWY);
        chk_lamps("ar_ew",    520, L_RED);
        chk_lamps("ar_ew_e",  539, L_RED);
        chk_lamps("period",   540, L_NSG);

        // ---- 3: early termination by conflicting demand ----
        ew_car = 1'b1;
        chk_lamps("early_nsg", 599, L_NSG);
        chk_lamps("early_nsy", 600, L_NSY);
        chk_lamps("early_ar",  640, L_RED);
        chk_lamps("early_ewg", 660, L_EWG);
        ew_car = 1'b0; ns_car = 1'b1;
        chk_lamps("early_ewg2", 719, L_EWG);
        chk_lamps("early_ewy",  720, L_EWY);
        chk_lamps("own_nsg",    780, L_NSG);
        chk_lamps("own_nsg_e",  979, L_NSG);
        chk_lamps("own_nsy",    980, L_NSY);
        chk_lamps("own_ewg",   1040, L_EWG);
        ns_car = 1'b0;
        chk_lamps("max_ewg_e", 1239, L_EWG);
        chk_lamps("max_ewy",   1240, L_EWY);
        chk_lamps("nsg_1300",  1300, L_NSG);

        // ---- 4: pedestrian walk ----
        run_to(1305);
        check("ped_idle", {7'b0, ped_pending}, 8'd0);
        ped_req = 1'b1;
        run_to(1306);
        ped_req = 1'b0;
        check("ped_latch", {7'b0, ped_pending}, 8'd1);
        chk_lamps("ped_nsg",   1359, L_NSG);
        chk_lamps("ped_nsy",   1360, L_NSY);
        chk_lamps("ped_ar",    1419, L_RED);
        check("ped_held", {7'b0, ped_pending}, 8'd1);
        chk_lamps("walk_beg",  1420, L_WALK);
        check("ped_clr", {7'b0, ped_pending}, 8'd0);
        run_to(1430);
        ped_req = 1'b1;
        run_to(1431);
        ped_req = 1'b0;
        check("ped_ignored", {7'b0, ped_pending}, 8'd0);
        chk_lamps("walk_end",  1499, L_WALK);
        chk_lamps("walk_ewg",  1500, L_EWG);

        // ---- 5: async reset in the middle of a walk ----
        run_to(1505);
        ped_req = 1'b1;
        run_to(1506);
        ped_req = 1'b0;
        chk_lamps("walk2_ewy", 1560, L_EWY);
        chk_lamps("walk2",     1630, L_WALK);
        #1 rst_n = 1'b0;
        #1;
        check("arst_lamps", {1'b0, lamps}, {1'b0, L_RED});
        check("arst_ped",   {7'b0, ped_pending}, 8'd0);
        check("arst_tick",  {7'b0, tick}, 8'd0);
        rst_n = 1'b1;
        cyc   = 0;
        run_to(18); check("re_tick18", {7'b0, tick}, 8'd0);
        run_to(19); check("re_tick19", {7'b0, tick}, 8'd1);
        chk_lamps("re_red19", 19, L_RED);
        chk_lamps("re_nsg20", 20, L_NSG);

        // ---- 6: random stimulus lamp-safety sweep ----
        for (int i = 0; i < 10000; i++) begin
            ns_car  = 1'($urandom_range(0, 1));
            ew_car  = 1'($urandom_range(0, 1));
            ped_req = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            cyc++;
            nonred = int'(ns_g | ns_y) + int'(ew_g | ew_y);
            check("ns_onehot", 8'($countones({ns_g, ns_y, ns_r})), 8'd1);
            check("ew_onehot", 8'($countones({ew_g, ew_y, ew_r})), 8'd1);
            check("one_head",  {7'b0, (nonred <= 1)}, 8'd1);
            check("walk_red",  {7'b0, (!walk || (ns_r && ew_r))}, 8'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Actuated intersection controller. It sequences the north-south (NS) and east-west (EW) signal heads and a pedestrian walk phase from vehicle-presence sensors and a pedestrian push-button. It generates its own timing tick from `clk` and exports it for benches and display logic. It sits directly above the lamp drivers and is the only source of lamp state in the intersection.

## Interface
- `TICK_DIV`, 20: clock cycles per tick (≥2).
- `GREEN_MIN`, 3: minimum green duration, in ticks (≥1).
- `GREEN_MAX`, 10: maximum green duration, in ticks (≥`GREEN_MIN`).
- `YELLOW_T`, 2: yellow duration, in ticks (≥1).
- `ALLRED_T`, 1: all-red clearance duration, in ticks (≥1).
- `WALK_T`, 4: pedestrian walk duration, in ticks (≥1).

- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ns_car` in 1: NS vehicle present (level, synchronous to `clk`).
- `ew_car` in 1: EW vehicle present (level).
- `ped_req` in 1: pedestrian button; a pulse of any length, minimum one cycle.
- `tick` out 1: one-cycle strobe, once every `TICK_DIV` cycles.
- `ns_g`, `ns_y`, `ns_r` out 1 each: NS lamps.
- `ew_g`, `ew_y`, `ew_r` out 1 each: EW lamps.
- `walk` out 1: pedestrian walk lamp.
- `ped_pending` out 1: a pedestrian request is latched and not yet served.

## Operation
- **Prescaler:** `div_cnt` counts 0..`TICK_DIV`-1 and wraps to 0. `tick` = (`div_cnt`==`TICK_DIV`-1).
- **States:** `NS_GREEN`, `NS_YELLOW`, `RED_AFTER_NS`, `EW_GREEN`, `EW_YELLOW`, `RED_AFTER_EW`, `PED_WALK`.
- **Phase timer:** `elapsed` counts ticks spent in the current state. It clears on state entry. Width is `$clog2(GREEN_MAX+1)`, and it saturates and never wraps.
- **State updates:** the state and `elapsed` change only on a clock edge where `tick`=1. Let e = `elapsed`+1 at that tick.
- **`NS_GREEN` → `NS_YELLOW`** when either:
  - e ≥ `GREEN_MAX`, or
  - e ≥ `GREEN_MIN` and (`ew_car` or `ped_pending`).
  - Otherwise NS stays green. `EW_GREEN` behaves the same way with `ns_car` as the conflicting demand.
- **Yellow → red:** `NS_YELLOW` → `RED_AFTER_NS` when e==`YELLOW_T`. `EW_YELLOW` → `RED_AFTER_EW` likewise.
- **`RED_AFTER_NS`, at e==`ALLRED_T`:** go to `PED_WALK` if `ped_pending`, else to `EW_GREEN`. `RED_AFTER_EW` is symmetric, going to `NS_GREEN` when there is no pedestrian request.
- **Direction after walk:** a 1-bit `next_dir` records the green direction owed after the walk. It is EW when entering from `RED_AFTER_NS` and NS when entering from `RED_AFTER_EW`.
- **`PED_WALK`:** at e==`WALK_T`, go to the green of `next_dir`. No additional all-red is inserted.
- **`ped_pending` latch:**
  - Set on any cycle with `ped_req`=1, except while in `PED_WALK`, where requests are ignored.
  - Cleared on the edge that enters `PED_WALK`. If set and clear fall on the same edge, clear wins.
- **Lamp decode (Moore):** lamps are a pure function of the state register, exactly one lamp per head.
  - Green: own head green, other head red.
  - Yellow: own head yellow, other head red.
  - `RED_*` and `PED_WALK`: both heads red.
  - `walk`=1 only in `PED_WALK`.
- **Safety invariant:** at most one head is non-red at any time, and `walk`=1 implies both heads are red.

## Timing
- **Reset values (while `rst_n`=0):**
  - state `RED_AFTER_EW`, `elapsed`=0, `div_cnt`=0, `next_dir`=NS.
  - `ped_pending`=0, `tick`=0.
  - `ns_r`=`ew_r`=1; all other lamps 0, `walk`=0.
- **Assertion mid-operation:** all of the above takes effect immediately, with no clock needed.
- **Release:** the first `tick` occurs in cycle `TICK_DIV`-1 after release.
  - With defaults, the edge ending cycle 19 enters `NS_GREEN`.
  - `ns_g` is high from cycle 20.
- **Lamp latency:** lamps change on the edge ending the tick cycle, i.e. one cycle after `tick` is observed high.
- **Sensor sampling:** `ns_car` and `ew_car` are sampled only in tick cycles. `ped_req` is sampled every cycle.
- **Fixed-time cycle with no demand (defaults), in ticks:**
  - NS green 10, yellow 2, all-red 1.
  - EW green 10, yellow 2, all-red 1.
  - Total period 26 ticks = 520 cycles.

## Structure
- **Shared package `traffic_pkg`:**
  - state encoding localparams, 3-bit binary;
  - direction constants `DIR_NS` and `DIR_EW`;
  - default timing constants.
- **Sub-module `tick_prescaler`** (parameter `TICK_DIV`; ports `clk`, `rst_n`, `tick`). It is reusable by other timing blocks.
- **Top-level contents:** the FSM, the phase timer, the pedestrian latch and the lamp decode.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles → `ns_r`=`ew_r`=1, other lamps 0, `walk`=0, `tick`=0. Release → first `tick` at cycle 19, `ns_g`=1 from cycle 20.
2. **No demand, defaults:** `ns_g` for 10 ticks, `ns_y` 2, all-red 1, `ew_g` 10, and so on. Check a 520-cycle period.
3. **Early termination:** `ew_car`=1 from NS-green tick 1 → `ns_y` on the tick where e=3 (`GREEN_MIN`), then all-red 1, then `ew_g`. With `ew_car`=0 and `ns_car`=1, NS green lasts the full 10 ticks.
4. **Pedestrian:** one-cycle `ped_req` during NS green → `ped_pending`=1 immediately. NS leaves green at e=3, then yellow 2, all-red 1, then `walk`=1 for 4 ticks with both heads red and `ped_pending`=0. Then `ew_g`. A `ped_req` during the walk leaves `ped_pending`=0.
5. **Async reset mid-walk:** pulse `rst_n` low for a fraction of a cycle during `PED_WALK` → `walk`=0 and both reds immediately. `ped_pending`=0, and the sequence restarts as in scenario 1.
6. **Safety over random stimulus (≥10,000 cycles):** run with random `ns_car`, `ew_car` and `ped_req` and check every cycle:
   - exactly one lamp is on per head;
   - never more than one head is non-red;
   - `walk` implies both heads red.
